// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial mux-based adder.
package serial_add_pkg;

  // Default operand/result width.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states: waiting for a request, or shifting bits through the cell.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Ceiling log2 with a floor of 1 so the counter never collapses to zero bits.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mux_full_add.sv
// One-bit full adder expressed purely as 2:1 mux selections.
module mux_full_add (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  logic bxc;

  // b^c as a mux on b, then the sum as a mux on a choosing xnor/xor.
  always_comb begin
    bxc = b ? ~c : c;
    s   = a ? ~bxc : bxc;
  end

  // Carry: with a=1 it is b|c, with a=0 it is b&c; both written as muxes on b.
  always_comb begin
    co = a ? (b ? 1'b1 : c) : (b ? c : 1'b0);
  end

endmodule

// File: rtl/serial_add_mux.sv
// Bit-serial WIDTH-bit adder: LSB first, one bit per clock through a mux-built cell.
module serial_add_mux
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = clog2_safe(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               cell_s;
  logic               cell_co;
  logic               accept_c;
  logic               last_c;
  logic               busy_nxt;
  logic               done_nxt;

  // Single bit cell, fed from the LSBs of the shifting operands and the running carry.
  mux_full_add u_cell (
    .a  (opa[0]),
    .b  (opb[0]),
    .c  (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  // Request acceptance, final-bit detection and the accumulator's next value.
  always_comb begin
    accept_c = (state == IDLE) && start;
    last_c   = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));
    acc_nxt  = {cell_s, acc[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: completion is the RUN to IDLE transition on the last bit.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)  state_nxt = RUN;
      RUN:  if (last_c) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Output decode: next values of the registered busy flag and done pulse.
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = start;
      end
      RUN: begin
        busy_nxt = !last_c;
        done_nxt = last_c;
      end
      default: begin
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
      end
    endcase
  end

  // Registered handshake outputs and result; the result only moves at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      if (last_c) begin
        sum  <= acc_nxt;
        cout <= cell_co;
      end
    end
  end

  // Operand capture on an accepted request, then one right shift per processed bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (accept_c) begin
      opa   <= a;
      opb   <= b;
      acc   <= '0;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      opa   <= {1'b0, opa[WIDTH-1:1]};
      opb   <= {1'b0, opb[WIDTH-1:1]};
      acc   <= acc_nxt;
      carry <= cell_co;
      cnt   <= last_c ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_serial_add_mux.sv
// Scoreboard bench for serial_add_mux (WIDTH=8) plus an exhaustive check of the bit cell.
module tb_serial_add_mux;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    int               done_edge;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  logic ca, cb, cc;
  logic cs, cco;

  exp_t sb[$];
  exp_t mon_e;
  int   edges;
  int   n_tests;
  int   n_fail;

  serial_add_mux #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  mux_full_add u_cell (
    .a  (ca),
    .b  (cb),
    .c  (cc),
    .s  (cs),
    .co (cco)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used to time done pulses against their start edge.
  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Drive one request at a negedge; optionally record what its completion must look like.
  task automatic drive_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                             input logic cv, input logic push,
                             input logic [WIDTH-1:0] es, input logic ec);
    exp_t e;
    a     = av;
    b     = bv;
    cin   = cv;
    start = 1'b1;
    if (push) begin
      e.sum       = es;
      e.cout      = ec;
      e.done_edge = edges + 1 + WIDTH;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (sb.size() == 0) begin
          n_tests = n_tests + 1;
          n_fail  = n_fail + 1;
          $display("FAIL unexpected_done: got done=1 expected no pending result (edge %0d)", edges);
        end else begin
          mon_e = sb.pop_front();
          chk("sum", 64'(sum), 64'(mon_e.sum));
          chk("cout", 64'(cout), 64'(mon_e.cout));
          chk("done_edge", 64'(edges), 64'(mon_e.done_edge));
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    cin     = 1'b0;
    ca      = 1'b0;
    cb      = 1'b0;
    cc      = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    @(negedge clk);

    // Zero operands, with busy window checked around the 8-cycle latency.
    drive_start(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    chk("busy_first", 64'(busy), 64'd1);
    repeat (7) @(negedge clk);
    chk("busy_last", 64'(busy), 64'd1);
    @(negedge clk);
    chk("busy_clear", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);

    drive_start(8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1);
    repeat (WIDTH + 2) @(negedge clk);

    drive_start(8'hA5, 8'h5A, 1'b1, 1'b1, 8'h00, 1'b1);
    repeat (WIDTH + 2) @(negedge clk);

    drive_start(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    repeat (WIDTH + 2) @(negedge clk);

    // Back-to-back: second request presented in the done cycle of the first.
    drive_start(8'h0F, 8'h01, 1'b0, 1'b1, 8'h10, 1'b0);
    repeat (WIDTH) @(negedge clk);
    chk("b2b_done_cycle", 64'(done), 64'd1);
    drive_start(8'h80, 8'h80, 1'b0, 1'b1, 8'h00, 1'b1);
    chk("b2b_sum_held", 64'(sum), 64'h10);
    chk("b2b_busy", 64'(busy), 64'd1);
    repeat (WIDTH + 2) @(negedge clk);

    // Start during RUN is ignored.
    drive_start(8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (WIDTH + 2) @(negedge clk);
    chk("ignored_sum", 64'(sum), 64'h46);

    // Reset mid-RUN aborts with no done pulse.
    drive_start(8'h33, 8'h44, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (WIDTH) @(negedge clk);
    chk("abort_no_done_sum", 64'(sum), 64'd0);

    drive_start(8'h33, 8'h44, 1'b0, 1'b1, 8'h77, 1'b0);
    repeat (WIDTH + 2) @(negedge clk);

    // Exhaustive bit-cell check against plain addition.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] e;
      v  = 3'(i);
      ca = v[2];
      cb = v[1];
      cc = v[0];
      #1;
      e = 2'(ca) + 2'(cb) + 2'(cc);
      chk("cell_s", 64'(cs), 64'(e[0]));
      chk("cell_co", 64'(cco), 64'(e[1]));
    end

    repeat (2) @(negedge clk);
    chk("pending_results", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_mux.md
Name: serial_add_mux

Overview:
- Bit-serial N-bit adder; successor to the mux-implemented half adder.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
- Per-bit arithmetic is done by a full-adder cell built only from 2:1 mux expressions.
- Start/busy/done handshake; the result is held in an output register.
- Used where area matters more than latency, and as the reference datapath for the mux-implementation exercises.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out, held with sum

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs/counter/carry=0. Takes effect immediately, independent of clk.
- States are IDLE and RUN. A completion is the RUN→IDLE transition.
- IDLE with start=1 at edge k:
  - capture a, b, cin into opA, opB and carry; clear the bit counter.
  - go to RUN; busy=1 from edge k.
- RUN, each edge: bit cell takes opA[0], opB[0], carry.
  - Its sum bit shifts into the MSB of the accumulator (right shift).
  - carry gets the cell carry-out; opA and opB shift right; counter increments.
- Edges k+1..k+WIDTH process bits 0..WIDTH-1. At edge k+WIDTH:
  - sum gets the final accumulator value; cout gets the final carry.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
  - Latency is WIDTH cycles from the start edge to done.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no overflow flag.
- Bit cell, mux form only (no + operator in the cell):
  - s = a ? ~(b^c) : (b^c), with b^c formed as b ? ~c : c.
  - co = a ? (b|c) : (b&c), written as muxes.
- start while busy=1 is ignored; no queueing; captured operands are unaffected.
- start=1 in the done cycle (state already IDLE) is accepted. Back-to-back operations run with no gap: done at edge k+WIDTH, next start accepted at edge k+WIDTH+1.
- sum/cout change only at completion or reset. They do not change on start capture; the previous result stays visible during RUN.
- Counter wraps only via the RUN→IDLE exit. Terminal count is WIDTH-1 at the last processed bit.
- rst asserted mid-RUN: abort, all state is cleared, no done pulse. The first start after rst deasserts is accepted normally.
- a/b/cin changing during RUN has no effect.

Decomposition:
- Package serial_add_pkg holds:
  - state enum {IDLE, RUN}
  - default WIDTH constant
  - function clog2_safe for CNT_W
- One sub-module, mux_full_add (inputs a, b, c; outputs s, co):
  - pure combinational, mux-only expressions as above
  - instantiated once in the datapath.
- The bench also checks mux_full_add exhaustively on its 8 input combinations.

Test Plan (WIDTH=8):
- Reset, then start with a=0x00, b=0x00, cin=0 → busy for 8 cycles; done pulse at start edge+8; sum=0x00, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, done exactly 8 cycles after the start edge, single-cycle width.
- a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- Back-to-back: start with a=0x0F, b=0x01, then start=1 in the done cycle with a=0x80, b=0x80 → results in order:
  - first: sum=0x10, cout=0
  - second: sum=0x00, cout=1
  - gap between the two done pulses is 8 cycles.
- start pulsed at cycle 3 of RUN with different operands → ignored; first result unchanged; no extra done.
- rst asserted at cycle 4 of RUN (a=0x33, b=0x44) → busy/done/sum/cout go to 0 immediately, no done pulse. Next start with a=0x33, b=0x44 → sum=0x77, cout=0.
